// File: rtl/axi_mem_pkg.sv
// Shared definitions for the AXI4 memory slave: response codes and engine FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/axi_mem_sram.sv
// DEPTH x DATA_W word array: one byte-enabled write port, one read port with a registered output.
// Latency: read data appears one cycle after rd_en; a same-cycle write to the read word returns old data.
// Backpressure: none; rd_data holds its value while rd_en is low.
// Ports: clk/rst, wr_en/wr_addr/wr_data/wr_strb (write port), rd_en/rd_addr/rd_data (read port).
module axi_mem_sram #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 1024,
    localparam int STRB_W = DATA_W / 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Sampling mem_q before the write edge lands gives read-before-write.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (wr_en && wr_strb[b]) begin
                mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave RAM (INCR, full-width beats) with independent, concurrent read and write engines.
// Latency: AW->wready 1 cycle, last W->bvalid 1 cycle, AR->first rvalid 1 cycle, then 1 beat/cycle.
// Backpressure: R/B outputs held stable while not ready; one transaction outstanding per engine.
// Ports: aclk/areset; AW (awid, awaddr, awlen), W (wdata, wstrb, wlast), B (bid, bresp);
//        AR (arid, araddr, arlen), R (rid, rdata, rresp, rlast); each with valid/ready.
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter  int ID_W   = 4,
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 1024,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [7:0]        awlen,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready
);

    localparam int OFFS  = $clog2(STRB_W);
    localparam int AW    = $clog2(DEPTH);
    // Word indices keep every upper address bit so that stepping past DEPTH-1 is seen as out of range.
    localparam int IDX_W = ADDR_W - OFFS;
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

    function automatic logic idx_oor(input logic [IDX_W-1:0] idx);
        return idx >= DEPTH_IDX;
    endfunction

    logic [IDX_W-1:0] aw_idx;
    logic [IDX_W-1:0] ar_idx;
    assign aw_idx = awaddr[ADDR_W-1:OFFS];
    assign ar_idx = araddr[ADDR_W-1:OFFS];

    // Byte-offset bits carry no information for full-width beats.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr, araddr};

    // ---------------- write engine ----------------
    w_state_t         w_state_q, w_state_d;
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic             bvalid_q, bvalid_d;
    logic [ID_W-1:0]  bid_q, bid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic [IDX_W-1:0] w_idx_q, w_idx_d;
    logic [7:0]       w_len_q, w_len_d;
    logic [7:0]       w_cnt_q, w_cnt_d;
    logic             w_err_q, w_err_d;
    logic             w_last_beat;
    logic             w_beat_err;
    logic             mem_we;

    always_comb begin
        w_state_d   = w_state_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        w_idx_d     = w_idx_q;
        w_len_d     = w_len_q;
        w_cnt_d     = w_cnt_q;
        w_err_d     = w_err_q;
        mem_we      = 1'b0;
        w_last_beat = (w_cnt_q == w_len_q);
        w_beat_err  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready_q) begin
                    bid_d     = awid;
                    w_idx_d   = aw_idx;
                    w_len_d   = awlen;
                    w_cnt_d   = 8'd0;
                    w_err_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    // Out-of-range beats are dropped; a misplaced wlast only taints the response.
                    mem_we     = !idx_oor(w_idx_q);
                    w_beat_err = idx_oor(w_idx_q) || (wlast != w_last_beat);
                    if (w_last_beat) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        w_idx_d = w_idx_q + IDX_W'(1);
                        w_cnt_d = w_cnt_q + 8'd1;
                        w_err_d = w_err_q || w_beat_err;
                    end
                end
            end
            W_RESP: begin
                if (bready && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
        end
    end

    // ---------------- read engine ----------------
    r_state_t         r_state_q, r_state_d;
    logic             arready_q, arready_d;
    logic             rvalid_q, rvalid_d;
    logic [ID_W-1:0]  rid_q, rid_d;
    logic [1:0]       rresp_q, rresp_d;
    logic             rlast_q, rlast_d;
    logic [IDX_W-1:0] r_idx_q, r_idx_d;
    logic [7:0]       r_len_q, r_len_d;
    logic [7:0]       r_cnt_q, r_cnt_d;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [DATA_W-1:0] sram_rdata;

    // The array is read only on AR acceptance and on each R handshake, so the
    // registered array output doubles as the hold register under backpressure.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        rd_en     = 1'b0;
        rd_addr   = r_idx_q[AW-1:0];
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    rd_en     = 1'b1;
                    rd_addr   = ar_idx[AW-1:0];
                    rresp_d   = idx_oor(ar_idx) ? RESP_SLVERR : RESP_OKAY;
                    rlast_d   = (arlen == 8'd0);
                    rid_d     = arid;
                    r_len_d   = arlen;
                    r_cnt_d   = 8'd0;
                    r_idx_d   = ar_idx + IDX_W'(1);
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rready && rvalid_q) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rresp_d   = RESP_OKAY;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        rd_en   = 1'b1;
                        rresp_d = idx_oor(r_idx_q) ? RESP_SLVERR : RESP_OKAY;
                        rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
                        r_idx_d = r_idx_q + IDX_W'(1);
                        r_cnt_d = r_cnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    axi_mem_sram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_sram (
        .clk     (aclk),
        .rst     (areset),
        .wr_en   (mem_we),
        .wr_addr (w_idx_q[AW-1:0]),
        .wr_data (wdata),
        .wr_strb (wstrb),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (sram_rdata)
    );

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rid     = rid_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    // Out-of-range beats and idle cycles present zero instead of whatever the array port holds.
    assign rdata   = (rvalid_q && (rresp_q == RESP_OKAY)) ? sram_rdata : '0;

endmodule
